// File: rtl/gat_feat_reader_pkg.sv
// Shared sizing, state encoding and helpers for the feature readback engine.
// Optional build macro used by the top: FEAT_READER_PERF_EN.
package gat_feat_reader_pkg;

    localparam int NEW_FEATURE_WIDTH  = 32;
    localparam int NUM_SUBGRAPHS      = 2708;
    localparam int NUM_FEATURE_OUT    = 16;
    localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
    localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);
    localparam int RD_LATENCY         = 2;
    localparam int FIFO_DEPTH         = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_e;

    // BRAM port B is byte addressed; words sit on 4-byte boundaries.
    function automatic logic [NEW_FEATURE_ADDR_W+1:0] word_to_byte(
        input logic [NEW_FEATURE_ADDR_W-1:0] w);
        return {w, 2'b00};
    endfunction

endpackage

// File: rtl/gat_feat_reader_if.sv
// AXI4-Stream bundle carrying readback words towards the host DMA.
interface gat_feat_reader_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gat_feat_reader_rd_fifo.sv
// Small synchronous FIFO with occupancy count; head word is always visible.
module gat_feat_rd_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]             cnt_q, cnt_d;

    // Next-state for storage, pointers and count; push+pop leaves count unchanged.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PW+1)'(DEPTH));

    // The credit scheme upstream must never push into a full FIFO without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/gat_feat_reader.sv
// Feature BRAM readback engine: issues byte addresses on port B, absorbs the
// fixed read latency through a valid pipe and streams words out over AXI4-Stream.
// Optional: define FEAT_READER_PERF_EN to get a per-transfer cycle counter.
module gat_feat_reader
    import gat_feat_reader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NEW_FEATURE_ADDR_W-1:0] base_word,
    input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    gat_feat_reader_if.master             m_axis,
    output logic [31:0]                   perf_cycles
);
    localparam int AW = NEW_FEATURE_ADDR_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e             state_q, state_d;
    logic [AW-1:0]         word_idx_q, word_idx_d;
    logic [AW:0]           issue_left_q, issue_left_d;
    logic [AW:0]           num_q, num_d;
    logic [AW:0]           push_cnt_q, push_cnt_d;
    logic [AW+1:0]         addrb_q, addrb_d;
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [CW-1:0]              fifo_cnt;
    logic [NEW_FEATURE_WIDTH:0] fifo_din, fifo_dout;
    logic                       fifo_empty, fifo_full;
    logic                       issue, push, pop, range_bad, accept;
    logic [AW+1:0]              end_word;
    logic [CW:0]                occupancy;

    // Words already committed (in FIFO or still in the BRAM pipe) bound new issues.
    always_comb begin
        end_word  = {2'b00, base_word} + {1'b0, num_words};
        range_bad = end_word > (AW+2)'(NEW_FEATURE_DEPTH);
        accept    = (state_q == IDLE) && start && !range_bad;
        occupancy = {1'b0, fifo_cnt} + (CW+1)'($countones(vld_pipe_q));
        issue     = (state_q == RUN) && (occupancy < (CW+1)'(FIFO_DEPTH));
        push      = vld_pipe_q[RD_LATENCY-1];
        pop       = m_axis.tvalid && m_axis.tready;
        fifo_din  = {push_cnt_q == num_q - 1'b1, feat_bram_dout};
    end

    // Transfer sequencing, address issue and valid-pipe shifting.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        issue_left_d = issue_left_q;
        num_d        = num_q;
        push_cnt_d   = push ? push_cnt_q + 1'b1 : push_cnt_q;
        addrb_d      = addrb_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        vld_pipe_d   = vld_pipe_q << 1;
        vld_pipe_d[0] = issue;
        case (state_q)
            IDLE: begin
                if (start && range_bad) begin
                    err_d = 1'b1;
                end else if (start) begin
                    busy_d       = 1'b1;
                    word_idx_d   = base_word;
                    issue_left_d = num_words;
                    num_d        = num_words;
                    push_cnt_d   = '0;
                    if (num_words == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addrb_d      = word_to_byte(word_idx_q);
                    word_idx_d   = word_idx_q + 1'b1;
                    issue_left_d = issue_left_q - 1'b1;
                    if (issue_left_q == (AW+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Finish as the last beat handshakes so done lands right after it.
                if (vld_pipe_q == '0 &&
                    (fifo_cnt == '0 || (fifo_cnt == CW'(1) && pop))) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            issue_left_q <= '0;
            num_q        <= '0;
            push_cnt_q   <= '0;
            addrb_q      <= '0;
            vld_pipe_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            issue_left_q <= issue_left_d;
            num_q        <= num_d;
            push_cnt_q   <= push_cnt_d;
            addrb_q      <= addrb_d;
            vld_pipe_q   <= vld_pipe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    gat_feat_rd_fifo #(
        .W     (NEW_FEATURE_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign m_axis.tvalid   = !fifo_empty;
    assign m_axis.tdata    = fifo_dout[NEW_FEATURE_WIDTH-1:0];
    assign m_axis.tlast    = fifo_dout[NEW_FEATURE_WIDTH] && !fifo_empty;
    assign feat_bram_addrb = addrb_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;

`ifdef FEAT_READER_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d, perf_q, perf_d;

    // Saturating busy-cycle count, published when the transfer completes.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (accept) perf_cnt_d = '0;
        else if (busy_q && perf_cnt_q != '1) perf_cnt_d = perf_cnt_q + 1'b1;
        perf_d = (state_q == DONE) ? perf_cnt_d : perf_q;
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_q     <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_gat_feat_reader.sv
// Self-checking bench: BRAM model word[i]=i*3, table vectors, random transfers
// and hand sequences for latency, reset abort and perf count.
module tb_gat_feat_reader;
    import gat_feat_reader_pkg::*;

    localparam int AW = NEW_FEATURE_ADDR_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_word = '0;
    logic [AW:0]   num_words = '0;
    logic          busy, done, err;
    logic [AW+1:0] addrb;
    logic [31:0]   dout;
    logic [31:0]   perf;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    gat_feat_reader_if #(.W(NEW_FEATURE_WIDTH)) axis ();

    gat_feat_reader u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .base_word       (base_word),
        .num_words       (num_words),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .feat_bram_addrb (addrb),
        .feat_bram_dout  (dout),
        .m_axis          (axis),
        .perf_cycles     (perf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: contents word[i] = i*3, data valid RD_LATENCY edges after addrb issue.
    always @(posedge clk) dout <= 32'(addrb >> 2) * 32'd3;

    // Event logger sampled on the falling edge.
    logic [31:0] bd_q[$];
    bit          bl_q[$];
    int          bc_q[$];
    int          dn_q[$];
    int          er_q[$];
    bit          eb_q[$];
    int          stall_viol = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (axis.tvalid && axis.tready) begin
                bd_q.push_back(axis.tdata);
                bl_q.push_back(axis.tlast);
                bc_q.push_back(cyc);
            end
            if (done) dn_q.push_back(cyc);
            if (err) begin
                er_q.push_back(cyc);
                eb_q.push_back(busy);
            end
            if (pv && !pr && !(axis.tvalid && axis.tdata == pd && axis.tlast == pl))
                stall_viol <= stall_viol + 1;
            pv <= axis.tvalid;
            pr <= axis.tready;
            pd <= axis.tdata;
            pl <= axis.tlast;
        end else begin
            pv <= 1'b0;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_ready(input int mode);
        case (mode)
            0:       axis.tready = 1'b1;
            1:       axis.tready = (cyc % 3 == 0);
            default: axis.tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One transfer; expectations come from the plain rules: words base..base+num-1,
    // value 3*index, tlast on the final one, err when the range leaves the BRAM.
    task automatic xfer(input int base, input int num, input int mode, input bit exp_err);
        int b0, d0, e0, s0, s, t, nb, exp_beats;
        b0 = bd_q.size(); d0 = dn_q.size(); e0 = er_q.size(); s0 = stall_viol;
        exp_beats = exp_err ? 0 : num;
        @(posedge clk); #1;
        base_word = AW'(base); num_words = (AW+1)'(num); start = 1'b1; s = cyc;
        drive_ready(mode);
        t = 0;
        while (dn_q.size() == d0 && er_q.size() == e0 && t < 4000) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mode == 1 && t == 10) begin
                base_word = '0; num_words = (AW+1)'(1); start = 1'b1;
            end
            drive_ready(mode);
            t++;
        end
        chk("timeout", t >= 4000, 0);
        repeat (4) begin @(posedge clk); #1; start = 1'b0; drive_ready(mode); end
        nb = bd_q.size() - b0;
        chk("beats", nb, exp_beats);
        for (int i = 0; i < nb && i < exp_beats; i++) begin
            chk("data", bd_q[b0+i], (base + i) * 3);
            chk("tlast", bl_q[b0+i], i == num - 1);
        end
        chk("err_cnt", er_q.size() - e0, exp_err);
        chk("done_cnt", dn_q.size() - d0, !exp_err);
        chk("stall", stall_viol - s0, 0);
        if (exp_err && er_q.size() > e0) begin
            chk("busy_at_err", eb_q[e0], 0);
            chk("err_lat", er_q[e0] - s, 1);
        end
        if (!exp_err && num > 0) chk("addrb_last", addrb, (base + num - 1) * 4);
        if (mode == 0 && !exp_err && dn_q.size() > d0) begin
            if (num > 0 && nb > 0) begin
                chk("first_lat", bc_q[b0] - s, RD_LATENCY + 2);
                chk("done_after_last", dn_q[d0] - bc_q[b0+nb-1], 1);
            end else if (num == 0) begin
                chk("done0_lat_le2", (dn_q[d0] - s) <= 2, 1);
            end
        end
    endtask

    typedef struct { int base; int num; int mode; bit exp_err; } vec_t;
    vec_t vecs[9];

    initial begin
        int room, base, num, nbeat, t;
        vecs[0] = '{0,     16, 0, 1'b0};
        vecs[1] = '{43312, 16, 0, 1'b0};
        vecs[2] = '{43320, 16, 0, 1'b1};
        vecs[3] = '{0,      0, 0, 1'b0};
        vecs[4] = '{100,   64, 1, 1'b0};
        vecs[5] = '{43327,  1, 2, 1'b0};
        vecs[6] = '{65535,  1, 0, 1'b1};
        vecs[7] = '{43328,  0, 0, 1'b0};
        vecs[8] = '{7,      3, 2, 1'b0};

        axis.tready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tlast", axis.tlast, 0);
        chk("rst_tdata", axis.tdata, 0);
        chk("rst_perf", perf, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int v = 0; v < 9; v++)
            xfer(vecs[v].base, vecs[v].num, vecs[v].mode, vecs[v].exp_err);

        for (int r = 0; r < 10; r++) begin
            base = $urandom_range(0, NEW_FEATURE_DEPTH - 1);
            room = NEW_FEATURE_DEPTH - base;
            num  = (r % 5 == 4) ? room + 1 + $urandom_range(0, 5)
                                : $urandom_range(0, room < 40 ? room : 40);
            xfer(base, num, 2, (base + num) > NEW_FEATURE_DEPTH);
        end

        // Reset in the middle of a 32-word transfer.
        nbeat = bd_q.size();
        @(posedge clk); #1;
        axis.tready = 1'b1; base_word = AW'(200); num_words = (AW+1)'(32); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t = 0;
        while (bd_q.size() - nbeat < 5 && t < 200) begin @(posedge clk); #1; t++; end
        chk("rst_mid_timeout", t >= 200, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", axis.tvalid, 0);
        chk("rst_mid_busy", busy, 0);
        nbeat = bd_q.size();
        t = dn_q.size();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_mid_no_beats", bd_q.size(), nbeat);
        chk("rst_mid_no_done", dn_q.size(), t);
        chk("rst_mid_idle", busy, 0);

        xfer(0, 16, 0, 1'b0);
`ifdef FEAT_READER_PERF_EN
        chk("perf16", perf, 20);
`else
        chk("perf_off", perf, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
